// File: rtl/decade_pkg.sv
// Shared types and helpers for the decade pulse transmitter.
package decade_pkg;

  // Transmitter control states.
  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StDone
  } state_e;

  // Largest legal value of a single BCD digit.
  localparam int unsigned BCD_MAX = 9;

  // True when a 4-bit digit is a legal BCD value.
  function automatic logic bcd_digit_valid(input logic [3:0] digit);
    return digit <= 4'(BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD down-counter. Loads a BCD word, decrements it by one with
// digit-to-digit borrow, and flags when the whole word is zero. A decrement
// request while already zero is dropped so the count never wraps.
module bcd_down_counter
  import decade_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic                  dec_i,
  input  logic [4*DIGITS-1:0]   load_val_i,
  output logic [4*DIGITS-1:0]   value_o,
  output logic                  zero_o
);

  logic [4*DIGITS-1:0] value_q, value_d;
  logic [4*DIGITS-1:0] dec_val;
  logic                borrow;

  // Ripple a single borrow from the least-significant digit upwards.
  always_comb begin
    dec_val = value_q;
    borrow  = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (borrow) begin
        if (value_q[4*d +: 4] == 4'd0) begin
          dec_val[4*d +: 4] = 4'(BCD_MAX);
        end else begin
          dec_val[4*d +: 4] = value_q[4*d +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  assign zero_o = (value_q == '0);

  // Next value: clear wins over load, load wins over decrement.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (dec_i && !zero_o) begin
      value_d = dec_val;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/decade_pulse_tx.sv
// Pulse-train transmitter: emits exactly the requested BCD count of clean
// pulses on pulse_o, with a start/ready/done handshake. Every output comes
// straight from a flop; the output stage trails the control state by one
// cycle, so a start accepted at edge k raises pulse_o at edge k+1. Abort is
// the exception: it clears pulse_o, busy and remaining on the same edge that
// returns the control state to idle.
module decade_pulse_tx
  import decade_pkg::*;
#(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned HIGH_CYCLES = 1,
  parameter int unsigned LOW_CYCLES  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                ready,
  output logic                busy,
  output logic                pulse_o,
  output logic                done,
  output logic                err,
  output logic [4*DIGITS-1:0] remaining
);

  localparam int unsigned MaxPhase = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned TimerW   = (MaxPhase > 1) ? $clog2(MaxPhase + 1) : 1;

  state_e              state_q;
  logic [TimerW-1:0]   timer_q;
  logic                ready_q;
  logic                busy_q;
  logic                pulse_q;
  logic                done_q;
  logic                err_q;
  logic [4*DIGITS-1:0] rem_q;

  logic                count_valid;
  logic                count_zero;
  logic                take;
  logic                in_phase;
  logic                aborting;
  logic                high_last;
  logic                low_last;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_clr;
  logic [4*DIGITS-1:0] cnt_value;
  logic                cnt_zero;

  // Check every digit of the requested count for BCD legality.
  always_comb begin
    count_valid = 1'b1;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (!bcd_digit_valid(bcd_in[4*d +: 4])) begin
        count_valid = 1'b0;
      end
    end
  end

  assign count_zero = (bcd_in == '0);
  // ready_q is only ever set while idle, so it also qualifies the state.
  assign take       = (state_q == StIdle) && ready_q && start;
  assign in_phase   = (state_q == StHigh) || (state_q == StLow);
  assign aborting   = in_phase && abort;
  assign high_last  = (timer_q == TimerW'(HIGH_CYCLES - 1));
  assign low_last   = (timer_q == TimerW'(LOW_CYCLES - 1));

  // Counter control: load on an accepted legal request, step once at the
  // end of every high phase, wipe on abort.
  always_comb begin
    cnt_load = take && count_valid;
    cnt_dec  = (state_q == StHigh) && high_last && !abort;
    cnt_clr  = aborting;
  end

  bcd_down_counter #(
    .DIGITS (DIGITS)
  ) u_count (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (bcd_in),
    .value_o    (cnt_value),
    .zero_o     (cnt_zero)
  );

  // Control FSM, phase timer and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rem_q   <= '0;
    end else begin
      // Output stage follows the state of the cycle just ending.
      err_q   <= 1'b0;
      done_q  <= (state_q == StDone);
      pulse_q <= (state_q == StHigh);
      busy_q  <= in_phase;
      ready_q <= 1'b0;
      rem_q   <= cnt_value;

      unique case (state_q)
        StIdle: begin
          timer_q <= '0;
          ready_q <= 1'b1;
          if (take) begin
            if (!count_valid) begin
              err_q <= 1'b1;
            end else begin
              ready_q <= 1'b0;
              state_q <= count_zero ? StDone : StHigh;
            end
          end
        end

        StHigh: begin
          if (abort) begin
            state_q <= StIdle;
            timer_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            rem_q   <= '0;
          end else if (high_last) begin
            timer_q <= '0;
            state_q <= StLow;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StLow: begin
          if (abort) begin
            state_q <= StIdle;
            timer_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
            rem_q   <= '0;
          end else if (low_last) begin
            timer_q <= '0;
            // cnt_zero already reflects the decrement from the high phase.
            state_q <= cnt_zero ? StDone : StHigh;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
        end

        StDone: begin
          // Hold ready low one more cycle so it rises after the done strobe.
          timer_q <= '0;
          state_q <= StIdle;
        end

        default: begin
          timer_q <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign pulse_o   = pulse_q;
  assign done      = done_q;
  assign err       = err_q;
  assign remaining = rem_q;

endmodule

// File: tb/tb_decade_pulse_tx.sv
// Bench for decade_pulse_tx: two instances (H=1/L=1 and H=3/L=2) checked every
// cycle against a timeline model, plus directed literal expectations.
module tb_decade_pulse_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [2];
  logic       abort_v [2];
  logic [7:0] bcd_v   [2];
  logic       ready_v [2];
  logic       busy_v  [2];
  logic       pulse_v [2];
  logic       done_v  [2];
  logic       err_v   [2];
  logic [7:0] rem_v   [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model state: running flag, cycles since the accepting edge, count, err strobe.
  bit m_run [2];
  int m_t   [2];
  int m_n   [2];
  bit m_err [2];

  // Event statistics gathered by the compare process.
  int  pulse_cnt [2];
  int  done_cnt  [2];
  int  done_cyc  [2];
  int  err_cnt   [2];
  int  busy_seen [2];
  logic prev_pulse [2];

  always #5 clk = ~clk;

  decade_pulse_tx #(
    .DIGITS (2), .HIGH_CYCLES (1), .LOW_CYCLES (1)
  ) u_dut0 (
    .clk (clk), .rst_n (rst_n), .start (start_v[0]), .abort (abort_v[0]),
    .bcd_in (bcd_v[0]), .ready (ready_v[0]), .busy (busy_v[0]), .pulse_o (pulse_v[0]),
    .done (done_v[0]), .err (err_v[0]), .remaining (rem_v[0])
  );

  decade_pulse_tx #(
    .DIGITS (2), .HIGH_CYCLES (3), .LOW_CYCLES (2)
  ) u_dut1 (
    .clk (clk), .rst_n (rst_n), .start (start_v[1]), .abort (abort_v[1]),
    .bcd_in (bcd_v[1]), .ready (ready_v[1]), .busy (busy_v[1]), .pulse_o (pulse_v[1]),
    .done (done_v[1]), .err (err_v[1]), .remaining (rem_v[1])
  );

  function automatic int hc(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int lc(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int total_cycles(input int i, input int n);
    return n * (hc(i) + lc(i));
  endfunction

  function automatic bit bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic int int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return int'(r);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d (0x%0h) expected %0d (0x%0h)",
               name, cyc, act, act, exp, exp);
    end
  endtask

  // Expected outputs from the transfer timeline: cycle t after the accepting
  // edge shows pulse index (t-1)/(H+L), high for the first H cycles of each period.
  task automatic expect_out(input int i, output int e_rdy, output int e_busy,
                            output int e_pulse, output int e_done, output int e_err,
                            output int e_rem);
    int p, per, tot;
    e_rdy = m_run[i] ? 0 : 1;
    e_busy = 0; e_pulse = 0; e_done = 0; e_rem = 0;
    e_err = m_err[i] ? 1 : 0;
    if (m_run[i] && m_t[i] > 0) begin
      p   = m_t[i] - 1;
      per = hc(i) + lc(i);
      tot = total_cycles(i, m_n[i]);
      if (p < tot) begin
        e_busy  = 1;
        e_pulse = ((p % per) < hc(i)) ? 1 : 0;
        e_rem   = int2bcd(m_n[i] - p / per - (((p % per) >= hc(i)) ? 1 : 0));
      end else begin
        e_done = 1;
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Timeline model.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] <= 1'b0;
        m_err[i] <= 1'b0;
        m_t[i]   <= 0;
        m_n[i]   <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_err[i] <= 1'b0;
        if (m_run[i]) begin
          if ((abort_v[i] && m_t[i] < total_cycles(i, m_n[i])) ||
              m_t[i] == total_cycles(i, m_n[i]) + 1) begin
            m_run[i] <= 1'b0;
          end else begin
            m_t[i] <= m_t[i] + 1;
          end
        end else if (start_v[i]) begin
          if (!bcd_ok(bcd_v[i])) begin
            m_err[i] <= 1'b1;
          end else begin
            m_run[i] <= 1'b1;
            m_t[i]   <= 0;
            m_n[i]   <= bcd2int(bcd_v[i]);
          end
        end
      end
    end
  end

  // Compare every output of both instances on every falling clock edge.
  initial begin
    int e_rdy, e_busy, e_pulse, e_done, e_err, e_rem;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        expect_out(i, e_rdy, e_busy, e_pulse, e_done, e_err, e_rem);
        chk($sformatf("ready%0d", i), int'(ready_v[i]), e_rdy);
        chk($sformatf("busy%0d", i), int'(busy_v[i]), e_busy);
        chk($sformatf("pulse%0d", i), int'(pulse_v[i]), e_pulse);
        chk($sformatf("done%0d", i), int'(done_v[i]), e_done);
        chk($sformatf("err%0d", i), int'(err_v[i]), e_err);
        chk($sformatf("remaining%0d", i), int'(rem_v[i]), e_rem);
        if (pulse_v[i] === 1'b1 && prev_pulse[i] !== 1'b1) pulse_cnt[i]++;
        if (done_v[i] === 1'b1) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (err_v[i] === 1'b1) err_cnt[i]++;
        if (busy_v[i] === 1'b1) busy_seen[i]++;
        prev_pulse[i] = pulse_v[i];
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stats(input int i);
    pulse_cnt[i] = 0;
    done_cnt[i]  = 0;
    done_cyc[i]  = -1;
    err_cnt[i]   = 0;
    busy_seen[i] = 0;
  endtask

  // Present a request for one edge; k is the number of the sampling edge.
  task automatic launch(input int i, input logic [7:0] v, output int k);
    step();
    bcd_v[i]   = v;
    start_v[i] = 1'b1;
    k = cyc + 1;
    step();
    start_v[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i, input int budget);
    int n = 0;
    while (ready_v[i] !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    chk($sformatf("ready_timeout%0d", i), int'(ready_v[i]), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int k;
    logic [14:0] pat;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      bcd_v[i]   = 8'h00;
      prev_pulse[i] = 1'b0;
      clear_stats(i);
    end
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Reset values.
    chk("rst_ready", int'(ready_v[0]), 1);
    chk("rst_busy", int'(busy_v[0]), 0);
    chk("rst_pulse", int'(pulse_v[0]), 0);
    chk("rst_done", int'(done_v[0]), 0);
    chk("rst_err", int'(err_v[0]), 0);
    chk("rst_remaining", int'(rem_v[0]), 0);

    // Ten pulses from 8'h10.
    clear_stats(0);
    launch(0, 8'h10, k);
    step();
    chk("t1_first_pulse", int'(pulse_v[0]), 1);
    chk("t1_rem_first", int'(rem_v[0]), 'h10);
    step();
    chk("t1_first_low", int'(pulse_v[0]), 0);
    chk("t1_rem_after_fall", int'(rem_v[0]), 'h09);
    wait_ready(0, 40);
    chk("t1_pulses", pulse_cnt[0], 10);
    chk("t1_done_cnt", done_cnt[0], 1);
    chk("t1_done_edge", done_cyc[0], k + 21);
    chk("t1_ready_edge", cyc, k + 22);

    // Zero count: done only.
    clear_stats(0);
    launch(0, 8'h00, k);
    wait_ready(0, 10);
    chk("t2_pulses", pulse_cnt[0], 0);
    chk("t2_busy_seen", busy_seen[0], 0);
    chk("t2_done_edge", done_cyc[0], k + 1);
    chk("t2_done_cnt", done_cnt[0], 1);

    // Illegal digit.
    clear_stats(0);
    launch(0, 8'h1A, k);
    chk("t3_err_now", int'(err_v[0]), 1);
    chk("t3_ready_now", int'(ready_v[0]), 1);
    repeat (3) step();
    chk("t3_err_cnt", err_cnt[0], 1);
    chk("t3_pulses", pulse_cnt[0], 0);
    chk("t3_done_cnt", done_cnt[0], 0);

    // Start re-asserted mid-run is ignored.
    clear_stats(0);
    launch(0, 8'h05, k);
    repeat (3) step();
    start_v[0] = 1'b1;
    bcd_v[0]   = 8'h07;
    step();
    start_v[0] = 1'b0;
    wait_ready(0, 30);
    chk("t4_pulses", pulse_cnt[0], 5);
    chk("t4_done_cnt", done_cnt[0], 1);

    // Abort during the third high phase (H=1).
    clear_stats(0);
    launch(0, 8'h05, k);
    repeat (4) step();
    abort_v[0] = 1'b1;
    step();
    abort_v[0] = 1'b0;
    chk("t4a_pulse", int'(pulse_v[0]), 0);
    chk("t4a_rem", int'(rem_v[0]), 0);
    chk("t4a_ready", int'(ready_v[0]), 1);
    repeat (3) step();
    chk("t4a_done_cnt", done_cnt[0], 0);
    chk("t4a_pulses", pulse_cnt[0], 2);

    // Abort while the third pulse is visibly high (H=3).
    clear_stats(1);
    launch(1, 8'h05, k);
    repeat (11) step();
    chk("t4b_pulse_high", int'(pulse_v[1]), 1);
    chk("t4b_rem_before", int'(rem_v[1]), 'h03);
    abort_v[1] = 1'b1;
    step();
    abort_v[1] = 1'b0;
    chk("t4b_pulse", int'(pulse_v[1]), 0);
    chk("t4b_rem", int'(rem_v[1]), 0);
    chk("t4b_ready", int'(ready_v[1]), 1);
    repeat (3) step();
    chk("t4b_done_cnt", done_cnt[1], 0);
    chk("t4b_pulses", pulse_cnt[1], 3);

    // Asynchronous reset mid-pulse.
    clear_stats(0);
    launch(0, 8'h05, k);
    step();
    chk("t5_pulse_before", int'(pulse_v[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_pulse", int'(pulse_v[0]), 0);
    chk("t5_ready", int'(ready_v[0]), 1);
    chk("t5_busy", int'(busy_v[0]), 0);
    chk("t5_rem", int'(rem_v[0]), 0);
    chk("t5_done", int'(done_v[0]), 0);
    chk("t5_err", int'(err_v[0]), 0);
    step();
    step();
    rst_n = 1'b1;
    clear_stats(0);
    launch(0, 8'h02, k);
    wait_ready(0, 20);
    chk("t5_pulses", pulse_cnt[0], 2);
    chk("t5_done_cnt", done_cnt[0], 1);

    // H=3, L=2, three pulses.
    clear_stats(1);
    launch(1, 8'h03, k);
    pat = '0;
    for (int j = 0; j < 15; j++) begin
      step();
      pat = {pat[13:0], pulse_v[1]};
    end
    chk("t6_pattern", int'(pat), int'(15'b111001110011100));
    wait_ready(1, 10);
    chk("t6_done_edge", done_cyc[1], k + 16);
    chk("t6_pulses", pulse_cnt[1], 3);
    chk("t6_done_cnt", done_cnt[1], 1);

    repeat (2) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decade_pulse_tx.md
Name: decade_pulse_tx

Overview:
Pulse-train transmitter that sits at the driving end of a decade counter's `in` line. It takes a multi-digit BCD count and emits exactly that many clean, registered pulses on `pulse_o`, so a downstream decade counter receives a known number of counts. It tracks the outstanding count with a BCD down-counter chain and reports completion over a simple start/ready/done handshake.

Parameters:
DIGITS, 2, number of BCD digits in the count (bcd_in width = 4*DIGITS); must be >= 1.
HIGH_CYCLES, 1, clock cycles pulse_o is held high per pulse; must be >= 1.
LOW_CYCLES, 1, clock cycles pulse_o is held low after each pulse; must be >= 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request; sampled only when ready=1.
abort  input  1  cancel the current transfer.
bcd_in  input  4*DIGITS  pulse count in BCD, least-significant digit in bits [3:0].
ready  output  1  high only in IDLE.
busy  output  1  high in HIGH and LOW states.
pulse_o  output  1  registered pulse output, driven straight from a flop.
done  output  1  one-cycle completion strobe.
err  output  1  one-cycle strobe when an invalid BCD digit is seen at start.
remaining  output  4*DIGITS  outstanding pulse count in BCD.

Behaviour:
- Interface: one clock, `clk`; reset `rst_n` is asynchronous, active-low.
- Reset value of every output: ready=1, busy=0, pulse_o=0, done=0, err=0, remaining=0. Assertion takes effect immediately, including mid-pulse; the timer and FSM clear to IDLE.
- FSM states: IDLE, HIGH, LOW, DONE.
- IDLE:
  - On start=1 with any digit of bcd_in >9: err=1 for the next cycle, state stays IDLE, remaining unchanged, no pulses.
  - On start=1 with a valid count of 0: go to DONE, no pulses.
  - On start=1 with a valid nonzero count N: load remaining=bcd_in and go to HIGH.
- HIGH: pulse_o=1 for HIGH_CYCLES cycles. In the last HIGH cycle, remaining is BCD-decremented: digit 0 becomes 9 with a borrow to the next digit; a digit of 9 or less without borrow just decrements. Then go to LOW.
- LOW: pulse_o=0 for LOW_CYCLES cycles. At the end of LOW, go to DONE if remaining==0, otherwise go to HIGH.
- DONE: done=1 for exactly one cycle, then go to IDLE. remaining reads 0 in DONE.
- Latency: for start sampled at edge k, pulse_o rises at edge k+1. done is high in the cycle after edge k+1+N*(HIGH_CYCLES+LOW_CYCLES). For N=0, that is the cycle after edge k+1.
- start while not ready is ignored; there is no queueing.
- abort in HIGH or LOW: next edge goes to IDLE with pulse_o=0 and remaining=0; no done strobe. abort in IDLE or DONE has no effect. If abort and start are both high in IDLE, start is serviced.
- The decrement never underflows: it is only applied while remaining is nonzero.
- The phase timer is sized to hold max(HIGH_CYCLES, LOW_CYCLES), with a minimum width of 1 bit.

Decomposition:
- Shared package `decade_pkg` holds:
  - the state enum;
  - constant BCD_MAX=9;
  - function bcd_digit_valid.
- Sub-module `bcd_down_counter` (parameter DIGITS) provides load, dec, a BCD value output and a zero flag. The top-level block owns the FSM, the phase timer and the handshake.

Test Plan:
1. DIGITS=2, H=1, L=1, bcd_in=8'h10, start at edge k -> exactly 10 pulses on pulse_o. remaining steps 10,09,...,00 on each pulse's falling edge. done is high for one cycle after edge k+21; ready returns the following cycle.
2. bcd_in=8'h00, start -> pulse_o stays 0, busy stays 0, done pulses in the cycle after edge k+1.
3. bcd_in=8'h1A, start -> err=1 for one cycle, ready stays 1, no pulses, no done.
4. bcd_in=8'h05 running, start re-asserted at pulse 2 -> ignored, total pulses = 5. New run, abort during the 3rd HIGH -> pulse_o=0 at the next edge, remaining=0, no done, ready=1.
5. rst_n driven low asynchronously mid-HIGH -> pulse_o=0 immediately without waiting for a clock edge, and all outputs at their reset values. After release, an 8'h02 transfer yields exactly 2 pulses.
6. H=3, L=2, bcd_in=8'h03 -> pulse_o pattern 111 00 111 00 111 00; done is high for one cycle after edge k+16. A connected decade counter sees exactly 3 counts.
